// File: rtl/bls12_381_pkg.sv
// Shared bls12_381 data RAM geometry, line format and the readback FSM states.
package bls12_381_pkg;

  localparam int DATA_RAM_DEPTH      = 8;
  localparam int DATA_RAM_WIDTH      = 384;
  localparam int DATA_RAM_ALIGN_BYTE = 64;
  localparam int DATA_RAM_USR_WIDTH  = 4;
  localparam int ADDR_BITS           = $clog2(DATA_RAM_DEPTH);
  localparam int SLOT_WORDS          = DATA_RAM_ALIGN_BYTE / DATA_RAM_USR_WIDTH;
  localparam int WORD_BITS           = 32;
  localparam int HOLD_BITS           = SLOT_WORDS * WORD_BITS;

  typedef enum logic [2:0] {
    SCALAR = 3'd0,
    FE     = 3'd1,
    FE2    = 3'd2,
    FE6    = 3'd3,
    FE12   = 3'd4,
    FP_AF  = 3'd5,
    FP2_AF = 3'd6
  } point_type_t;

  typedef struct packed {
    logic [380:0] dat;
    point_type_t  pt;
  } data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } rd_state_t;

endpackage

// File: rtl/bls12_381_slot_serializer.sv
// Holds one data RAM line and streams it as SLOT_WORDS 32-bit words over valid/ready.
module bls12_381_slot_serializer
  import bls12_381_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  data_t       i_line,
  input  logic        i_rdy,
  output logic [31:0] o_dat,
  output logic        o_val,
  output logic        o_sop,
  output logic        o_eop,
  output logic        o_last_hs
);

  localparam int WB = $clog2(SLOT_WORDS);

  logic [HOLD_BITS-1:0] r_hold;
  logic [WB-1:0]        r_w;
  logic [31:0]          r_dat;
  logic                 r_val;
  logic                 r_sop;
  logic                 r_eop;
  logic                 w_hs;
  logic                 w_last;
  logic [WB-1:0]        w_w_nxt;

  assign w_hs      = r_val & i_rdy;
  assign w_last    = (r_w == WB'(SLOT_WORDS - 1));
  assign w_w_nxt   = r_w + WB'(1);
  assign o_last_hs = w_hs & w_last;

  // Output word is pre-selected one handshake ahead so every output stays a flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold <= '0;
      r_w    <= '0;
      r_dat  <= 32'd0;
      r_val  <= 1'b0;
      r_sop  <= 1'b0;
      r_eop  <= 1'b0;
    end else if (i_load) begin
      r_hold <= {{(HOLD_BITS - DATA_RAM_WIDTH){1'b0}}, i_line};
      r_w    <= '0;
      r_dat  <= i_line[31:0];
      r_val  <= 1'b1;
      r_sop  <= 1'b1;
      r_eop  <= 1'b0;
    end else if (w_hs) begin
      if (w_last) begin
        r_w   <= '0;
        r_dat <= 32'd0;
        r_val <= 1'b0;
        r_sop <= 1'b0;
        r_eop <= 1'b0;
      end else begin
        r_w   <= w_w_nxt;
        r_dat <= r_hold[{w_w_nxt, 5'd0} +: 32];
        r_sop <= 1'b0;
        r_eop <= (w_w_nxt == WB'(SLOT_WORDS - 1));
      end
    end
  end

  assign o_dat = r_dat;
  assign o_val = r_val;
  assign o_sop = r_sop;
  assign o_eop = r_eop;

endmodule

// File: rtl/bls12_381_data_ram_rd.sv
// Host readback engine: reads N consecutive data RAM slots and streams each as 16 words.
// Optional point-type check enabled by defining BLS12_381_RD_TYPE_CHK_EN.
module bls12_381_data_ram_rd
  import bls12_381_pkg::*;
#(
  parameter int RAM_RD_LAT = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req_val,
  input  logic [ADDR_BITS-1:0]      i_req_slot,
  input  logic [3:0]                i_req_len,
  input  logic [2:0]                i_req_pt,
  output logic                      o_req_rdy,
  output logic                      o_ram_re,
  output logic [ADDR_BITS-1:0]      o_ram_addr,
  input  logic [DATA_RAM_WIDTH-1:0] i_ram_dat,
  output logic [31:0]               o_dat,
  output logic                      o_val,
  output logic                      o_sop,
  output logic                      o_eop,
  input  logic                      i_rdy,
  output logic                      o_busy,
  output logic                      o_type_err
);

  localparam int CNT_W = $clog2(RAM_RD_LAT + 1);

  rd_state_t            r_state;
  logic [3:0]           r_len;
  logic [ADDR_BITS-1:0] r_ram_addr;
  logic                 r_ram_re;
  logic                 r_req_rdy;
  logic                 r_busy;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_load;
  logic                 w_last_hs;
  logic                 w_req_hs;
  data_t                w_line;

  assign w_line   = data_t'(i_ram_dat);
  assign w_load   = (r_state == WAIT) && (r_cnt == CNT_W'(1));
  assign w_req_hs = i_req_val & r_req_rdy;

  // Request, RAM read and per-slot sequencing; the slot address doubles as the slot counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_len      <= 4'd0;
      r_ram_addr <= '0;
      r_ram_re   <= 1'b0;
      r_req_rdy  <= 1'b1;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_hs && (i_req_len != 4'd0)) begin
            r_len      <= i_req_len;
            r_ram_addr <= i_req_slot;
            r_ram_re   <= 1'b1;
            r_req_rdy  <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RD;
          end
        end
        RD: begin
          r_ram_re <= 1'b0;
          r_cnt    <= CNT_W'(RAM_RD_LAT);
          r_state  <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_last_hs) begin
            r_len      <= r_len - 4'd1;
            r_ram_addr <= r_ram_addr + ADDR_BITS'(1);
            if (r_len == 4'd1) begin
              r_req_rdy <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_ram_re <= 1'b1;
              r_state  <= RD;
            end
          end
        end
        default: begin
          r_ram_re  <= 1'b0;
          r_req_rdy <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  bls12_381_slot_serializer u_ser (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load),
    .i_line    (w_line),
    .i_rdy     (i_rdy),
    .o_dat     (o_dat),
    .o_val     (o_val),
    .o_sop     (o_sop),
    .o_eop     (o_eop),
    .o_last_hs (w_last_hs)
  );

`ifdef BLS12_381_RD_TYPE_CHK_EN
  point_type_t r_req_pt;
  logic        r_type_err;

  // Flag fires on the capture edge so it lines up with the slot's first valid word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_pt   <= SCALAR;
      r_type_err <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_req_hs) begin
        r_req_pt <= point_type_t'(i_req_pt);
      end
      r_type_err <= w_load && (w_line.pt != r_req_pt);
    end
  end

  assign o_type_err = r_type_err;
`else
  logic w_unused_pt;
  assign w_unused_pt = ^i_req_pt;
  assign o_type_err  = 1'b0;
`endif

  assign o_req_rdy  = r_req_rdy;
  assign o_ram_re   = r_ram_re;
  assign o_ram_addr = r_ram_addr;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_bls12_381_data_ram_rd.sv
// Randomized bench for bls12_381_data_ram_rd with a word-level reference model of the RAM readback.
module tb_bls12_381_data_ram_rd;
  import bls12_381_pkg::*;

  localparam int LAT = 2;
`ifdef BLS12_381_RD_TYPE_CHK_EN
  localparam bit TYPE_CHK = 1'b1;
`else
  localparam bit TYPE_CHK = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      req_val = 1'b0;
  logic [ADDR_BITS-1:0]      req_slot = '0;
  logic [3:0]                req_len = 4'd0;
  logic [2:0]                req_pt = 3'd0;
  logic                      o_req_rdy, o_ram_re, o_val, o_sop, o_eop, o_busy, o_type_err;
  logic [ADDR_BITS-1:0]      o_ram_addr;
  logic [DATA_RAM_WIDTH-1:0] ram_dat;
  logic [31:0]               o_dat;
  logic                      i_rdy = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  bls12_381_data_ram_rd #(.RAM_RD_LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_val(req_val), .i_req_slot(req_slot),
    .i_req_len(req_len), .i_req_pt(req_pt), .o_req_rdy(o_req_rdy), .o_ram_re(o_ram_re),
    .o_ram_addr(o_ram_addr), .i_ram_dat(ram_dat), .o_dat(o_dat), .o_val(o_val),
    .o_sop(o_sop), .o_eop(o_eop), .i_rdy(i_rdy), .o_busy(o_busy), .o_type_err(o_type_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_RAM_WIDTH-1:0] rand_line();
    logic [DATA_RAM_WIDTH-1:0] v;
    for (int i = 0; i < DATA_RAM_WIDTH / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // RAM model: fixed read latency, garbage on the bus when no read is in flight
  logic [DATA_RAM_WIDTH-1:0] ram  [DATA_RAM_DEPTH];
  logic [DATA_RAM_WIDTH-1:0] pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= o_ram_re ? ram[o_ram_addr] : rand_line();
  end
  assign ram_dat = pipe[LAT-1];

  typedef struct {
    logic [31:0] dat;
    logic        sop;
    logic        eop;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          addr_q[$];
  int          cyc = 0;
  int          last_hs = 0;
  int          re_seen = 0;
  int          words_in_slot = 0;
  int          err_pulses = 0;
  int          rdy_mode = 0;
  int          stall_left = 0;
  bit          grab_first = 1'b0;
  logic [31:0] first_word = 32'd0;
  logic        prev_val = 1'b0, prev_rdy = 1'b0, prev_sop = 1'b0, prev_eop = 1'b0;
  logic [31:0] prev_dat = 32'd0;

  task automatic push_model(input int s, input int l, input int p);
    logic [HOLD_BITS-1:0] big;
    exp_t e;
    for (int k = 0; k < l; k++) begin
      int a;
      a = (s + k) % DATA_RAM_DEPTH;
      addr_q.push_back(a);
      big = {{(HOLD_BITS - DATA_RAM_WIDTH){1'b0}}, ram[a]};
      for (int j = 0; j < SLOT_WORDS; j++) begin
        e.dat = big[32*j +: 32];
        e.sop = (j == 0);
        e.eop = (j == SLOT_WORDS - 1);
        e.err = TYPE_CHK && (j == 0) && (int'(ram[a][2:0]) != p);
        exp_q.push_back(e);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor / scoreboard, sampled on the falling edge
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_val = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      bit first;
      bit exp_err;
      if (exp_q.size() == 0 && addr_q.size() == 0) begin
        check_eq("idle_busy", o_busy, 0);
        check_eq("idle_req_rdy", o_req_rdy, 1);
        check_eq("idle_val", o_val, 0);
      end else begin
        check_eq("run_busy", o_busy, 1);
        check_eq("run_req_rdy", o_req_rdy, 0);
      end
      if (addr_q.size() == 0) check_eq("re_spurious", o_ram_re, 0);
      else if (o_ram_re) begin
        check_eq("ram_addr", o_ram_addr, addr_q.pop_front());
        re_seen++;
      end
      if (prev_val && !prev_rdy) begin
        check_eq("hold_val", o_val, 1);
        check_eq("hold_dat", o_dat, prev_dat);
        check_eq("hold_sop", o_sop, prev_sop);
        check_eq("hold_eop", o_eop, prev_eop);
      end
      first = o_val && !prev_val;
      if (first) begin
        check_eq("val_latency", cyc - last_hs, 2 + LAT);
        check_eq("first_sop", o_sop, 1);
      end
      exp_err = first && (exp_q.size() > 0) && exp_q[0].err;
      check_eq("type_err", o_type_err, exp_err);
      if (o_type_err) err_pulses++;
      if (o_val && i_rdy && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("dat", o_dat, e.dat);
        check_eq("sop", o_sop, e.sop);
        check_eq("eop", o_eop, e.eop);
        if (grab_first) begin
          first_word = o_dat;
          grab_first = 1'b0;
        end
        if (e.eop) begin
          last_hs = cyc;
          words_in_slot = 0;
        end else begin
          words_in_slot++;
        end
      end
      if (req_val && o_req_rdy) begin
        last_hs = cyc;
        if (req_len != 4'd0) push_model(int'(req_slot), int'(req_len), int'(req_pt));
      end
      prev_val = o_val;
      prev_rdy = i_rdy;
      prev_dat = o_dat;
      prev_sop = o_sop;
      prev_eop = o_eop;
    end
  end

  // Downstream ready driver
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: i_rdy = 1'b1;
      1: i_rdy = ($urandom_range(0, 3) != 0);
      2: begin
        if (o_val && words_in_slot == 7 && stall_left > 0) begin
          i_rdy = 1'b0;
          stall_left--;
        end else begin
          i_rdy = 1'b1;
        end
      end
      default: i_rdy = 1'b1;
    endcase
  end

  task automatic do_req(input int s, input int l, input int p);
    @(posedge clk);
    #1;
    req_val  = 1'b1;
    req_slot = ADDR_BITS'(s);
    req_len  = 4'(l);
    req_pt   = 3'(p);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (o_req_rdy) break;
    end
    check_eq("req_accept", o_req_rdy, 1);
    @(posedge clk);
    #1;
    req_val = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !o_busy) break;
    end
    @(negedge clk);
    check_eq("drain_words", exp_q.size(), 0);
    check_eq("drain_busy", o_busy, 0);
  endtask

  task automatic check_reset_state();
    check_eq("rst_req_rdy", o_req_rdy, 1);
    check_eq("rst_val", o_val, 0);
    check_eq("rst_sop", o_sop, 0);
    check_eq("rst_eop", o_eop, 0);
    check_eq("rst_dat", o_dat, 0);
    check_eq("rst_ram_re", o_ram_re, 0);
    check_eq("rst_ram_addr", o_ram_addr, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_type_err", o_type_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [383:0] gx_v;
    int           pulses0;
    gx_v = 384'h17f1d3a73197d7942695638c4fa9ac0fc3688c4f9774b905a14e3a3f171bac586c55e83ff97a1aeffb3af00adb22c6bb;
    for (int a = 0; a < DATA_RAM_DEPTH; a++) begin
      ram[a] = rand_line();
      ram[a][2:0] = 3'($urandom_range(0, 6));
    end
    ram[0] = {gx_v[380:0], 3'd1};
    ram[2][2:0] = 3'd2;

    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single slot, Gx line
    grab_first = 1'b1;
    do_req(0, 1, 1);
    wait_idle();
    check_eq("gx_word0", first_word, 32'hD91635D9);

    // wrap-around burst
    do_req(6, 4, int'(ram[6][2:0]));
    wait_idle();

    // backpressure at word 7
    rdy_mode = 2;
    stall_left = 5;
    do_req(1, 2, int'(ram[1][2:0]));
    wait_idle();
    check_eq("stall_applied", stall_left, 0);
    rdy_mode = 0;

    // zero-length request and a request held off while busy
    do_req(4, 0, 0);
    repeat (8) @(negedge clk);
    do_req(3, 2, int'(ram[3][2:0]));
    do_req(5, 1, int'(ram[5][2:0]));
    wait_idle();

    // type mismatch on slot 2
    pulses0 = err_pulses;
    do_req(2, 1, 1);
    wait_idle();
    check_eq("type_err_pulses", err_pulses - pulses0, TYPE_CHK ? 1 : 0);

    // reset during WAIT of the second slot
    re_seen = 0;
    do_req(3, 3, int'(ram[3][2:0]));
    for (int t = 0; t < 200; t++) begin
      if (re_seen >= 2) break;
      @(negedge clk);
    end
    check_eq("reset_point_reached", re_seen, 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    exp_q.delete();
    addr_q.delete();
    words_in_slot = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    do_req(5, 1, int'(ram[5][2:0]));
    wait_idle();

    // randomized requests with random backpressure
    for (int n = 0; n < 16; n++) begin
      rdy_mode = $urandom_range(0, 1);
      do_req($urandom_range(0, 7), $urandom_range(0, 8), $urandom_range(0, 6));
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    rdy_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
